// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a 2-entry skid buffer, flush and bubble-safe control output.
// Optional statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_reg #(
    parameter int                  DATA_W   = 64,
    parameter int                  CTRL_W   = 8,
    parameter logic [CTRL_W-1:0]   CTRL_BUB = {CTRL_W{1'b0}},
    parameter int                  CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              ready_q;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic              in_xfer;
    logic              out_xfer;
    logic              load_m;
    logic              load_s;
    logic              m_from_s;

    assign in_xfer  = in_valid & ready_q;
    assign out_xfer = out_valid & out_ready;

    // in_ready is a flop loaded with the decoded next occupancy, so it never depends on out_ready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != FULL);
        end
    end

    always_comb begin
        next_state = state;
        load_m     = 1'b0;
        load_s     = 1'b0;
        m_from_s   = 1'b0;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        load_m     = 1'b1;
                        next_state = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_m = 1'b1;
                    end else if (out_xfer) begin
                        next_state = EMPTY;
                    end else if (in_xfer) begin
                        load_s     = 1'b1;
                        next_state = FULL;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        m_from_s   = 1'b1;
                        next_state = ONE;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = ready_q;
        out_valid = (state != EMPTY);
        out_data  = m_data;
        out_ctrl  = out_valid ? m_ctrl : CTRL_BUB;
    end

    // Data and control of one instruction always move together between slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data <= '0;
            m_ctrl <= CTRL_BUB;
            s_data <= '0;
            s_ctrl <= '0;
        end else begin
            if (load_m) begin
                m_data <= in_data;
                m_ctrl <= in_ctrl;
            end else if (m_from_s) begin
                m_data <= s_data;
                m_ctrl <= s_ctrl;
            end
            if (load_s) begin
                s_data <= in_data;
                s_ctrl <= in_ctrl;
            end
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    // Both counters saturate at all-ones and are cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_ONE;
            end
            if (!out_valid && (bubble_q != {CNT_W{1'b1}})) begin
                bubble_q <= bubble_q + CNT_ONE;
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (DATA_W=16, CTRL_W=8, CNT_W=4).
// Counter expectations follow whether PIPE_STAGE_STATS_EN is defined for the build.
module tb_pipe_stage_reg;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;
    localparam logic [CTRL_W-1:0] BUB = 8'h00;
`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNT_W-1:0] SAT_EXP = 4'hF;
`else
    localparam logic [CNT_W-1:0] SAT_EXP = 4'h0;
`endif

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    int checks;
    int failures;

    pipe_stage_reg #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_BUB (BUB),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle, so inputs set before tick are the ones that edge sees.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_out_data got=%h exp=0000", out_data); end
        checks++;
        if (out_ctrl !== BUB) begin failures++; $display("[TB] FAIL reset_out_ctrl got=%h exp=%h", out_ctrl, BUB); end
        checks++;
        if (stall_cnt !== 4'h0 || bubble_cnt !== 4'h0) begin
            failures++; $display("[TB] FAIL reset_counters got=%h/%h exp=0/0", stall_cnt, bubble_cnt);
        end
    endtask

    task automatic test_stream;
        logic [DATA_W-1:0] exp_data;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 8'h01;
        for (int k = 0; k < 8; k++) begin
            exp_data = 16'h0010 + 16'(k);
            in_data  = exp_data;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_data) begin
                failures++; $display("[TB] FAIL stream_data[%0d] got=%b/%h exp=1/%h", k, out_valid, out_data, exp_data);
            end
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL stream_in_ready[%0d] got=%b exp=1", k, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_skid;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h02;
        in_data   = 16'h00A0;
        tick();
        in_data = 16'h00A1;
        tick();
        in_data = 16'h00A2;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h00A0) begin
            failures++; $display("[TB] FAIL skid_hold got=%b/%h exp=1/00a0", out_valid, out_data);
        end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL skid_full_ready got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h00A1) begin
            failures++; $display("[TB] FAIL skid_second got=%b/%h exp=1/00a1", out_valid, out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL skid_ready_back got=%b exp=1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h00A2) begin
            failures++; $display("[TB] FAIL skid_third got=%b/%h exp=1/00a2", out_valid, out_data);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL skid_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'hFF;
        in_data   = 16'h00B0;
        tick();
        in_data = 16'h00B1;
        tick();
        flush   = 1'b1;
        in_data = 16'h00B2;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== BUB) begin
            failures++; $display("[TB] FAIL flush_bubble got=%b/%h exp=0/%h", out_valid, out_ctrl, BUB);
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_in_ready got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_no_leak got=%b exp=0", out_valid); end
        in_valid = 1'b1;
        in_ctrl  = 8'h03;
        in_data  = 16'h00C0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h00C0 || out_ctrl !== 8'h03) begin
            failures++; $display("[TB] FAIL flush_refill got=%b/%h/%h exp=1/00c0/03", out_valid, out_data, out_ctrl);
        end
        tick();
    endtask

    task automatic test_ctrl_bubble;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 8'h5A;
        in_data   = 16'h0055;
        tick();
        in_valid = 1'b0;
        in_ctrl  = 8'h00;
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 8'h5A) begin
            failures++; $display("[TB] FAIL ctrl_valid got=%b/%h exp=1/5a", out_valid, out_ctrl);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== BUB) begin
            failures++; $display("[TB] FAIL ctrl_bubble got=%b/%h exp=0/%h", out_valid, out_ctrl, BUB);
        end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h77;
        in_data   = 16'h00D0;
        tick();
        in_data = 16'h00D1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== BUB || in_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL async_reset got=%b/%h/%b exp=0/%h/1", out_valid, out_ctrl, in_ready, BUB);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 4'h0 || bubble_cnt !== 4'h0) begin
            failures++; $display("[TB] FAIL reset_release_counters got=%h/%h exp=0/0", stall_cnt, bubble_cnt);
        end
        tick();
    endtask

    task automatic test_stats;
        // A run of idle cycles fills bubble_cnt, then a long stall fills stall_cnt.
        out_ready = 1'b0;
        in_valid  = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        checks++;
        if (bubble_cnt !== SAT_EXP) begin failures++; $display("[TB] FAIL bubble_saturate got=%h exp=%h", bubble_cnt, SAT_EXP); end
        in_valid = 1'b1;
        in_data  = 16'h00E0;
        in_ctrl  = 8'h04;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        checks++;
        if (stall_cnt !== SAT_EXP) begin failures++; $display("[TB] FAIL stall_saturate got=%h exp=%h", stall_cnt, SAT_EXP); end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h00E0) begin
            failures++; $display("[TB] FAIL stall_hold got=%b/%h exp=1/00e0", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        test_reset();
        rst = 1'b0;
        #1;
        test_stream();
        test_skid();
        test_flush();
        test_ctrl_bubble();
        test_reset_midstream();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
